// File: rtl/maze_tick_pkg.sv
// rtl/maze_tick_pkg.sv - shared state, config record and divider helpers for the maze tick scheduler
package maze_tick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } sched_state_t;

  localparam int CFG_CH_MAX_W     = 8;
  localparam int CFG_PERIOD_MAX_W = 32;

  typedef struct packed {
    logic [CFG_CH_MAX_W-1:0]     ch;
    logic [CFG_PERIOD_MAX_W-1:0] period;
  } cfg_req_t;

  function automatic int calc_div(input int clk_hz, input int base_hz);
    return clk_hz / base_hz;
  endfunction

  function automatic bit div_ok(input int clk_hz, input int base_hz);
    return (base_hz > 0) && (clk_hz % base_hz == 0) && (clk_hz / base_hz >= 2);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - shared base-tick prescaler, counts 0..DIV-1 while enabled
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic strobe
);

  localparam int PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= (pre == LAST) ? '0 : pre + PRE_W'(1);
    end
  end

  assign strobe = en && (pre == LAST);

endmodule

// File: rtl/maze_tick_sched.sv
// rtl/maze_tick_sched.sv - maze game timing scheduler: one prescaler, N_CH programmable tick channels
module maze_tick_sched
  import maze_tick_pkg::*;
#(
  parameter int CLK_HZ   = 100000000,
  parameter int BASE_HZ  = 1000,
  parameter int N_CH     = 4,
  parameter int PERIOD_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic                         restart,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [$clog2(N_CH+1)-1:0]    cfg_ch,
  input  logic [PERIOD_W-1:0]          cfg_period,
  output logic                         base_tick,
  output logic [N_CH-1:0]              tick,
  output logic [1:0]                   state
);

  localparam int DIV = calc_div(CLK_HZ, BASE_HZ);

  if (!div_ok(CLK_HZ, BASE_HZ)) begin : g_bad_div
    $error("CLK_HZ / BASE_HZ must be an integer of at least 2");
  end
  if (PERIOD_W > CFG_PERIOD_MAX_W || $clog2(N_CH + 1) > CFG_CH_MAX_W) begin : g_bad_width
    $error("channel or period width exceeds the config record");
  end

  sched_state_t     st;
  logic             strobe;
  logic             ready_q;
  logic             base_q;
  cfg_req_t         pend;
  logic             accept;
  logic             commit;
  logic [N_CH-1:0]  commit_hit;

  // An empty pending slot is exactly what cfg_ready advertises.
  assign accept = cfg_valid && ready_q && !restart;
  assign commit = !ready_q && !restart && ((st != ST_RUN) || strobe);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= ST_IDLE;
    end else if (restart) begin
      st <= ST_IDLE;
    end else begin
      case (st)
        ST_IDLE:  if (run)  st <= ST_RUN;
        ST_RUN:   if (!run) st <= ST_PAUSE;
        ST_PAUSE: if (run)  st <= ST_RUN;
        default:            st <= ST_IDLE;
      endcase
    end
  end

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (st == ST_RUN),
    .clr    (restart),
    .strobe (strobe)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b1;
      pend    <= '0;
    end else if (restart) begin
      ready_q <= 1'b1;
    end else if (accept) begin
      ready_q     <= 1'b0;
      pend.ch     <= CFG_CH_MAX_W'(cfg_ch);
      pend.period <= CFG_PERIOD_MAX_W'(cfg_period);
    end else if (commit) begin
      ready_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= 1'b0;
    end else begin
      base_q <= strobe && !restart;
    end
  end

  // Out-of-range channel numbers match no channel, so the commit is a no-op.
  always_comb begin
    commit_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (commit && (int'(pend.ch) == i)) commit_hit[i] = 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] cnt;
    logic                pulse;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        period <= '0;
        cnt    <= '0;
        pulse  <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (restart) begin
          cnt <= '0;
        end else if (commit_hit[i]) begin
          period <= PERIOD_W'(pend.period);
          cnt    <= '0;
        end else if (strobe && (period != '0)) begin
          if (cnt == period - PERIOD_W'(1)) begin
            cnt   <= '0;
            pulse <= 1'b1;
          end else begin
            cnt <= cnt + PERIOD_W'(1);
          end
        end
      end
    end

    assign tick[i] = pulse;
  end

  assign cfg_ready = ready_q;
  assign base_tick = base_q;
  assign state     = st;

endmodule

// File: tb/tb_maze_tick_sched.sv
// tb/tb_maze_tick_sched.sv - directed checks for maze_tick_sched with DIV = 10, N_CH = 4
module tb_maze_tick_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        restart = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [2:0]  cfg_ch = '0;
  logic [15:0] cfg_period = '0;
  logic        cfg_ready;
  logic        base_tick;
  logic [3:0]  tick;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0] got;
  logic [4:0] want;

  maze_tick_sched #(
    .CLK_HZ   (100),
    .BASE_HZ  (10),
    .N_CH     (4),
    .PERIOD_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .restart    (restart),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .base_tick  (base_tick),
    .tick       (tick),
    .state      (state)
  );

  always #5 clk = ~clk;

  assign got = {tick, base_tick};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL reset_state got=%b want=00", state); end
    n_cmp++; if (got !== 5'b0) begin n_bad++; $display("FAIL reset_pulses got=%b want=00000", got); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", cfg_ready); end
    rst = 1'b0;
    step();
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL idle_after_reset got=%b want=00", state); end
  endtask

  task automatic test_run_basic();
    logic b;
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_period = 16'd3;
    step();
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL idle_cfg0_busy got=%b want=0", cfg_ready); end
    cfg_valid = 1'b0;
    step();
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL idle_cfg0_done got=%b want=1", cfg_ready); end
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_period = 16'd1;
    step();
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL idle_cfg1_busy got=%b want=0", cfg_ready); end
    cfg_valid = 1'b0;
    step();
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL idle_cfg1_done got=%b want=1", cfg_ready); end
    n_cmp++; if (got !== 5'b0) begin n_bad++; $display("FAIL idle_no_pulses got=%b want=00000", got); end
    run = 1'b1;
    step();
    n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL enter_run got=%b want=01", state); end
    for (int k = 1; k <= 74; k++) begin
      step();
      b = (k % 10 == 0);
      want = {2'b00, b, (k % 30 == 0), b};
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL run_pulses k=%0d got=%b want=%b", k, got, want); end
    end
  endtask

  task automatic test_pause();
    logic b;
    run = 1'b0;
    for (int p = 1; p <= 50; p++) begin
      step();
      n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL pause_state p=%0d got=%b want=10", p, state); end
      n_cmp++; if (got !== 5'b0) begin n_bad++; $display("FAIL pause_quiet p=%0d got=%b want=00000", p, got); end
    end
    run = 1'b1;
    step();
    n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL resume_state got=%b want=01", state); end
    for (int k = 1; k <= 20; k++) begin
      step();
      b = (k % 10 == 5);
      want = {2'b00, b, (k == 15), b};
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL resume_pulses k=%0d got=%b want=%b", k, got, want); end
    end
  endtask

  task automatic test_cfg_in_run();
    logic b;
    for (int k = 21; k <= 28; k++) begin
      step();
      b = (k % 10 == 5);
      want = {2'b00, b, 1'b0, b};
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL prewrite_pulses k=%0d got=%b want=%b", k, got, want); end
    end
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_period = 16'd2;
    for (int k = 29; k <= 34; k++) begin
      step();
      if (k == 29) begin cfg_ch = 3'd2; cfg_period = 16'd7; end
      n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL run_cfg_busy k=%0d got=%b want=0", k, cfg_ready); end
      n_cmp++; if (got !== 5'b0) begin n_bad++; $display("FAIL run_cfg_quiet k=%0d got=%b want=00000", k, got); end
    end
    cfg_valid = 1'b0;
    for (int k = 35; k <= 60; k++) begin
      step();
      if (k == 35) begin
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL run_cfg_done got=%b want=1", cfg_ready); end
      end
      b = (k % 10 == 5);
      want = {2'b00, b, (k == 55), b};
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL run_cfg_pulses k=%0d got=%b want=%b", k, got, want); end
    end
  endtask

  task automatic test_commit_on_strobe();
    logic b;
    step();
    n_cmp++; if (got !== 5'b0) begin n_bad++; $display("FAIL collide_pre got=%b want=00000", got); end
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_period = 16'd4;
    step();
    cfg_valid = 1'b0;
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL collide_busy got=%b want=0", cfg_ready); end
    for (int k = 63; k <= 106; k++) begin
      step();
      if (k == 65) begin
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL collide_done got=%b want=1", cfg_ready); end
      end
      b = (k % 10 == 5);
      want = {2'b00, (k == 105), (k == 75 || k == 95), b};
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL collide_pulses k=%0d got=%b want=%b", k, got, want); end
    end
  endtask

  task automatic test_restart();
    logic b;
    cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_period = 16'd2;
    step();
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL restart_pend_busy got=%b want=0", cfg_ready); end
    cfg_valid = 1'b0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL restart_idle got=%b want=00", state); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL restart_ready got=%b want=1", cfg_ready); end
    n_cmp++; if (got !== 5'b0) begin n_bad++; $display("FAIL restart_quiet got=%b want=00000", got); end
    step();
    n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL restart_rerun got=%b want=01", state); end
    for (int k = 1; k <= 40; k++) begin
      step();
      b = (k % 10 == 0);
      want = {2'b00, (k == 40), (k % 20 == 0), b};
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL restart_pulses k=%0d got=%b want=%b", k, got, want); end
    end
  endtask

  task automatic test_bad_ch_and_async_rst();
    logic b;
    run = 1'b0;
    step();
    n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL badch_pause got=%b want=10", state); end
    cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_period = 16'd9;
    step();
    cfg_valid = 1'b0;
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL badch_busy got=%b want=0", cfg_ready); end
    step();
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL badch_done got=%b want=1", cfg_ready); end
    run = 1'b1;
    step();
    n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL badch_resume got=%b want=01", state); end
    for (int k = 1; k <= 38; k++) begin
      step();
      b = (k % 10 == 9);
      want = {2'b00, 1'b0, (k == 19), b};
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL badch_pulses k=%0d got=%b want=%b", k, got, want); end
    end
    cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_period = 16'd1;
    step();
    cfg_valid = 1'b0;
    n_cmp++; if (got !== 5'b00111) begin n_bad++; $display("FAIL badch_tick39 got=%b want=00111", got); end
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL pre_rst_busy got=%b want=0", cfg_ready); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL async_rst_state got=%b want=00", state); end
    n_cmp++; if (got !== 5'b0) begin n_bad++; $display("FAIL async_rst_pulses got=%b want=00000", got); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL async_rst_ready got=%b want=1", cfg_ready); end
    step();
    rst = 1'b0;
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_basic();
    test_pause();
    test_cfg_in_run();
    test_commit_on_strobe();
    test_restart();
    test_bad_ch_and_async_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
